// File: rtl/hb_uart_pkg.sv
// hb_uart_pkg: shared FSM encoding, default sync byte and frame-length helper for the UART framer
package hb_uart_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, DATA, CSUM, END} state_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  function automatic int frame_len(input int data_w, input bit add_csum);
    return 1 + data_w / 8 + int'(add_csum);
  endfunction
endpackage

// File: rtl/hb_sample_fifo.sv
// hb_sample_fifo: first-word-fall-through sample FIFO (ports: clk, rst, push, pop, din, dout, count, full, empty)
module hb_sample_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= din;
endmodule

// File: rtl/hb_uart_framer.sv
// hb_uart_framer: frames buffered filter samples as SYNC, data bytes MSB first, optional XOR checksum (ports: clk, rst, in_data, in_flag, tx_data, tx_valid, tx_ready, busy, ovf_cnt, frame_cnt)
module hb_uart_framer
  import hb_uart_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int FIFO_DEPTH = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter bit ADD_CSUM = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_flag,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [7:0]        ovf_cnt,
  output logic [15:0]       frame_cnt
);
  localparam int NB = DATA_W / 8;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  state_t state, state_n;
  logic [DATA_W-1:0] sreg, sreg_n, dout;
  logic [IW-1:0] idx, idx_n;
  logic [7:0] csum, csum_n, tx_data_n;
  logic tx_valid_n, push, pop, full, empty, xfer, last;
  logic [$clog2(FIFO_DEPTH):0] count;
  assign xfer = tx_valid & tx_ready;
  assign pop = state == IDLE && !empty;
  assign push = in_flag && (!full || pop);
  assign last = idx == IW'(NB - 1);
  assign busy = state != IDLE || count != '0;
  hb_sample_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(in_data),
    .dout(dout), .count(count), .full(full), .empty(empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg <= '0;
      idx <= '0;
      csum <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      ovf_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      sreg <= sreg_n;
      idx <= idx_n;
      csum <= csum_n;
      tx_data <= tx_data_n;
      tx_valid <= tx_valid_n;
      if (in_flag && !push && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      if (state == END) frame_cnt <= frame_cnt + 16'd1;
    end
  end
  always_comb begin
    state_n = state;
    sreg_n = sreg;
    idx_n = idx;
    csum_n = csum;
    tx_data_n = tx_data;
    tx_valid_n = tx_valid;
    case (state)
      IDLE: if (pop) begin
        sreg_n = dout;
        csum_n = '0;
        tx_data_n = SYNC_BYTE;
        tx_valid_n = 1'b1;
        state_n = SYNC;
      end
      SYNC: if (xfer) begin
        tx_data_n = sreg[DATA_W-1 -: 8];
        sreg_n = sreg << 8;
        idx_n = '0;
        state_n = DATA;
      end
      DATA: if (xfer) begin
        csum_n = csum ^ tx_data;
        tx_data_n = last ? csum_n : sreg[DATA_W-1 -: 8];
        tx_valid_n = !last || ADD_CSUM;
        sreg_n = sreg << 8;
        idx_n = idx + 1'b1;
        state_n = !last ? DATA : ADD_CSUM ? CSUM : END;
      end
      CSUM: if (xfer) begin
        tx_valid_n = 1'b0;
        state_n = END;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hb_uart_framer.sv
// tb_hb_uart_framer: directed self-checking bench with a frame-level queue model of the framer
module tb_hb_uart_framer;
  import hb_uart_pkg::*;
  localparam int D = 4;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [63:0] in_data = '0;
  logic in_flag = 0, tx_ready = 0;
  logic [7:0] tx_data, ovf_cnt;
  logic tx_valid, busy;
  logic [15:0] frame_cnt;
  hb_uart_framer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_flag(in_flag), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .ovf_cnt(ovf_cnt), .frame_cnt(frame_cnt)
  );
  logic [15:0] in2 = '0;
  logic flag2 = 0, ready2 = 0;
  logic [7:0] tx_data2, ovf2;
  logic tx_valid2, busy2;
  logic [15:0] frames2;
  hb_uart_framer #(.DATA_W(16), .ADD_CSUM(1'b0)) dut2 (
    .clk(clk), .rst(rst), .in_data(in2), .in_flag(flag2), .tx_data(tx_data2),
    .tx_valid(tx_valid2), .tx_ready(ready2), .busy(busy2), .ovf_cnt(ovf2), .frame_cnt(frames2)
  );
  int n_chk = 0, n_fail = 0;
  bit live = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  logic [63:0] fq[$];
  logic [7:0] bq[$], log1[$], log2[$];
  bit endp = 0;
  int m_ovf = 0;
  logic [15:0] m_frames = '0;
  function automatic void add_frame(input logic [63:0] s);
    logic [7:0] c = '0;
    bq.push_back(8'hA5);
    for (int i = 7; i >= 0; i--) begin
      bq.push_back(s[i*8 +: 8]);
      c ^= s[i*8 +: 8];
    end
    bq.push_back(c);
  endfunction
  function automatic bit m_idle();
    return bq.size() == 0 && !endp;
  endfunction
  function automatic bit m_busy();
    return !m_idle() || fq.size() > 0;
  endfunction
  always @(posedge clk) begin
    bit popm;
    if (rst) begin
      fq.delete();
      bq.delete();
      endp = 0;
      m_ovf = 0;
      m_frames = '0;
    end else begin
      popm = m_idle() && fq.size() > 0;
      if (bq.size() > 0 && tx_ready) begin
        void'(bq.pop_front());
        if (bq.size() == 0) endp = 1;
      end else if (endp) begin
        endp = 0;
        m_frames++;
      end
      if (popm) add_frame(fq.pop_front());
      if (in_flag) begin
        if (fq.size() < D) fq.push_back(in_data);
        else if (m_ovf < 255) m_ovf++;
      end
    end
  end
  always @(negedge clk) if (live) begin
    chk("tx_valid", 64'(tx_valid), 64'(bq.size() > 0));
    if (bq.size() > 0) chk("tx_data", 64'(tx_data), 64'(bq[0]));
    chk("busy", 64'(busy), 64'(m_busy()));
    chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
    chk("frame_cnt", 64'(frame_cnt), 64'(m_frames));
  end
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) log1.push_back(tx_data);
    if (!rst && tx_valid2 && ready2) log2.push_back(tx_data2);
  end
  logic [7:0] exp1[10] = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h00};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [63:0] d);
    in_data = d;
    in_flag = 1;
    tick();
    in_flag = 0;
  endtask
  task automatic drain(input string name);
    int k = 0;
    while (m_busy() && k < 300) begin
      tick();
      k++;
    end
    if (k == 300) chk({name, " drain timeout"}, 64'(k), 64'(0));
    tick();
  endtask
  task automatic chk_frame(input string name);
    chk({name, " length"}, 64'(log1.size()), 64'(frame_len(64, 1'b1)));
    for (int i = 0; i < 10; i++) chk({name, " byte"}, 64'(log1[i]), 64'(exp1[i]));
  endtask
  initial begin
    @(posedge clk);
    #1 live = 1;
    chk("reset tx_valid", 64'(tx_valid), 64'(0));
    chk("reset tx_data", 64'(tx_data), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset frame_cnt", 64'(frame_cnt), 64'(0));
    tick();
    rst = 0;
    tx_ready = 1;
    log1.delete();
    send(64'h0123_4567_89AB_CDEF);
    chk("latency edge k", 64'(tx_valid), 64'(0));
    tick();
    chk("latency edge k+1 valid", 64'(tx_valid), 64'(1));
    chk("latency edge k+1 sync", 64'(tx_data), 64'hA5);
    drain("single");
    chk_frame("single");
    chk("single frame_cnt", 64'(frame_cnt), 64'(1));
    log1.delete();
    in_data = 64'h0123_4567_89AB_CDEF;
    in_flag = 1;
    for (int c = 0; c < 60; c++) begin
      tx_ready = (c % 3 == 2);
      tick();
      in_flag = 0;
    end
    tx_ready = 1;
    drain("stall");
    chk_frame("stall");
    chk("stall frame_cnt", 64'(frame_cnt), 64'(2));
    tx_ready = 0;
    log1.delete();
    for (int i = 1; i <= 6; i++) send({8{8'(i * 17)}});
    chk("burst ovf_cnt", 64'(ovf_cnt), 64'(1));
    chk("burst busy", 64'(busy), 64'(1));
    tx_ready = 1;
    drain("burst");
    chk("burst bytes", 64'(log1.size()), 64'(50));
    chk("burst frame 5 byte", 64'(log1[41]), 64'h55);
    chk("burst frame_cnt", 64'(frame_cnt), 64'(7));
    tx_ready = 0;
    for (int i = 1; i <= 5; i++) send({4{16'(i * 4369)}});
    tx_ready = 1;
    begin
      int k = 0;
      @(negedge clk);
      while (!(m_idle() && fq.size() == D) && k < 40) begin
        @(negedge clk);
        k++;
      end
      if (k == 40) chk("popedge wait timeout", 64'(k), 64'(0));
    end
    in_data = 64'hFEDC_BA98_7654_3210;
    in_flag = 1;
    tick();
    in_flag = 0;
    chk("popedge ovf_cnt", 64'(ovf_cnt), 64'(1));
    drain("popedge");
    chk("popedge frame_cnt", 64'(frame_cnt), 64'(13));
    send(64'h0123_4567_89AB_CDEF);
    repeat (5) tick();
    chk("pre-reset byte3", 64'(tx_data), 64'h67);
    rst = 1;
    tick();
    rst = 0;
    chk("mid reset tx_valid", 64'(tx_valid), 64'(0));
    chk("mid reset ovf_cnt", 64'(ovf_cnt), 64'(0));
    chk("mid reset busy", 64'(busy), 64'(0));
    log1.delete();
    send(64'h0123_4567_89AB_CDEF);
    drain("after reset");
    chk_frame("after reset");
    chk("after reset frame_cnt", 64'(frame_cnt), 64'(1));
    ready2 = 1;
    in2 = 16'h8001;
    flag2 = 1;
    tick();
    flag2 = 0;
    repeat (8) tick();
    chk("w16 length", 64'(log2.size()), 64'(frame_len(16, 1'b0)));
    chk("w16 byte0", 64'(log2[0]), 64'hA5);
    chk("w16 byte1", 64'(log2[1]), 64'h80);
    chk("w16 byte2", 64'(log2[2]), 64'h01);
    chk("w16 frame_cnt", 64'(frames2), 64'(1));
    ready2 = 0;
    flag2 = 1;
    repeat (300) tick();
    flag2 = 0;
    tick();
    chk("w16 ovf saturate", 64'(ovf2), 64'hFF);
    chk("w16 busy", 64'(busy2), 64'(1));
    chk("w16 held valid", 64'(tx_valid2), 64'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
